expand_sampler: RTL and testbench
=================================

# expand_sampler

Parametrised successor to the ML-DSA matrix expander. One rejection-sampling engine serves ExpandA (RejNTTPoly, FIPS 204 Alg. 30/32) and ExpandS (RejBoundedPoly, Alg. 31/33), selected per run by `mode`. The block drives an external SHAKE core through its absorb/squeeze handshakes and consumes the squeeze stream directly through a bit buffer, with no block cache. Accepted coefficients are packed into the NTT data RAM.

## Interface
- `K`, 8: rows of A; also the s2 count.
- `L`, 7: columns of A; also the s1 count.
- `ETA`, 2: ExpandS bound; legal values are 2 and 4.
- `N`, 256: coefficients per polynomial.
- `Q`, 8380417: modulus.
- `DATA_W`, 64: SHAKE in/out word width. Must divide 256.
- `COEFF_WIDTH`, 24: stored coefficient width.
- `COEFF_PER_WORD`, 4: coefficients packed per RAM word, LSB first. Must divide N.
- `NTT_ADDR_WIDTH`, 12: RAM address width.
- `MAT_BASE`, 0: word offset of A.
- `S_BASE`, 0: word offset of s1‖s2.
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; ignored while `busy`.
- `mode` in 1: 0 = ExpandA, 1 = ExpandS; sampled on `start`.
- `busy` out 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse after the last RAM write.
- `seed_addr` out 3: seed word index.
- `seed_data` in DATA_W: seed word; 1-cycle read latency. ρ is 256 bits for ExpandA; ρ′ is 512 bits for ExpandS.
- `absorb_next` out 1: one-cycle pulse that resets the SHAKE state before each polynomial.
- `shake_data_in` out DATA_W: absorb data.
- `in_valid` out 1: absorb word valid.
- `in_last` out 1: marks the final absorb word.
- `last_len` out clog2(DATA_W)+1: constant 16.
- `in_ready` in 1: SHAKE absorb ready.
- `shake_data_out` in DATA_W: squeeze data.
- `out_valid` in 1: squeeze word valid.
- `out_ready` out 1: squeeze word accepted.
- `we` out 1: RAM write strobe.
- `addr` out NTT_ADDR_WIDTH: RAM write address.
- `din` out COEFF_WIDTH*COEFF_PER_WORD: RAM write data.

## Operation
**Polynomial count and order**
- ExpandA produces K·L polynomials, with r (row) as the outer loop and s (column) as the inner loop.
- ExpandS produces L+K polynomials with r = 0..L+K−1.
- Polynomial p is written to words `BASE + p·(N/COEFF_PER_WORD) + c/COEFF_PER_WORD`.

**States**
- IDLE → on `start`, go to INIT.
- INIT: pulse `absorb_next`; clear the bit buffer, coefficient count and pack register. → ABSORB.
- ABSORB: stream SEEDBITS/DATA_W seed words with `in_valid`=1 and `in_last`=0.
  - A word is transferred on `in_valid && in_ready`.
  - `seed_addr` is issued one cycle ahead.
  - → NONCE.
- NONCE: one word with `in_last`=1. Low 16 bits carry the nonce; upper bits are 0.
  - ExpandA nonce is {8'r, 8's}, so the low byte is s.
  - ExpandS nonce is 16-bit r, little-endian.
  - → SAMPLE once the word is transferred.
- SAMPLE: load and test candidates (rules below).
  - When the coefficient count reaches N: drop `out_ready`, discard the buffer, → NEXT.
- NEXT: advance the polynomial index. If it was the last polynomial → DONE, else → INIT.
- DONE: pulse `done`. → IDLE.

**Bit buffer and candidates** (buffer is DATA_W+24 bits, LSB first)
- Candidate width CW is 24 in ExpandA and 4 in ExpandS.
- `out_ready` = SAMPLE && left < CW. An accepted word is OR'd in at offset `left`, and `left` += DATA_W.
- When left ≥ CW, one candidate per cycle is consumed: shift right by CW, `left` −= CW.
- ExpandA rule: z = buf[22:0] (bit 23 masked). Accept if z < Q; the coefficient is z.
- ExpandS, ETA=2: accept if z < 15; the coefficient is 2 − (z mod 5).
- ExpandS, ETA=4: accept if z < 9; the coefficient is 4 − z.
- Negative ExpandS values are stored as Q + value, so every stored coefficient lies in [0, Q).

**Packing**
- Accepted coefficients go to slot `cnt mod COEFF_PER_WORD` of the pack register.
- When a slot fills the word: `we`=1 for one cycle, with `din`/`addr` valid the same cycle; the pack register is then cleared.

## Timing
**Reset**
- Synchronous, active-low. On `rst_n`=0 at a clock edge, every output is 0 on the following cycle and the FSM is IDLE.
- Mid-run reset abandons the run with no further writes. The SHAKE core is resynchronised by `absorb_next` at the next `start`.

**Handshake rules**
- `in_valid` and its data hold stable until `in_ready`.
- `out_ready` is never asserted outside SAMPLE.
- With `out_valid` low, SAMPLE stalls with no write.
- A word load and a candidate consume never occur in the same cycle.

**Latency**
- ExpandA: about 1 + SEEDWORDS + 1 cycles to absorb, plus 1 cycle per candidate, plus 1 cycle per loaded word.
- `done` follows the last `we` by 2 cycles.

**Boundary conditions**
- The N-th accepted coefficient always completes a word (COEFF_PER_WORD divides N).
- Leftover buffered bits are dropped and never carried into the next polynomial.
- `start` during `busy` has no effect.

## Test plan
- **Reset values:** hold `rst_n`=0 for 3 cycles, then release → all outputs 0, `busy`=0; after 10 idle cycles no `we`.
- **ExpandA reject/accept:** K=L=1; stub SHAKE emits bytes FF FF FF, then 01 00 00 repeated → first coefficient is 1; `din` word 0 = {24'd1, 24'd1, 24'd1, 24'd1}; 64 writes; `done` once.
- **ExpandA nonce:** K=L=2 → absorb nonce words 0x0000, 0x0001, 0x0100, 0x0101 in order; polynomial 2 lands at MAT_BASE+128.
- **ExpandS ETA=2:** stream nibbles F, 3 → 0xF rejected; 3 stored as 8380416 (Q−1). With ETA=4, nibbles 9, 0 → 9 rejected; 0 stored as 4. Nonces run 0..L+K−1.
- **Backpressure:** random `in_ready`/`out_valid` gaps → written RAM image identical to the zero-stall run; data held stable during stalls.
- **Mid-run reset:** drop `rst_n` during polynomial 3's SAMPLE → no `we` after reset; a fresh `start` produces the full correct image.

Source files
------------

// File: rtl/expand_sampler.sv
// ----------------------------------------------------------------------------
// expand_sampler
//
// Rejection-sampling engine shared by ExpandA (RejNTTPoly) and ExpandS
// (RejBoundedPoly). For every polynomial it resets an external SHAKE core,
// absorbs the seed plus a 16-bit nonce, then pulls squeeze words into a bit
// buffer and tests candidates one per cycle. Accepted coefficients are
// packed LSB first into RAM words and written out.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   start, mode         : run request (mode 0 = ExpandA, 1 = ExpandS)
//   busy, done          : run in progress / one-cycle completion pulse
//   seed_addr/seed_data : seed word read port (1-cycle latency)
//   absorb_next         : SHAKE state reset pulse before each polynomial
//   shake_data_in, in_valid, in_last, last_len, in_ready : absorb stream
//   shake_data_out, out_valid, out_ready                 : squeeze stream
//   we, addr, din       : packed coefficient RAM write port
// ----------------------------------------------------------------------------
module expand_sampler #(
    parameter int K              = 8,
    parameter int L              = 7,
    parameter int ETA            = 2,
    parameter int N              = 256,
    parameter int Q              = 8380417,
    parameter int DATA_W         = 64,
    parameter int COEFF_WIDTH    = 24,
    parameter int COEFF_PER_WORD = 4,
    parameter int NTT_ADDR_WIDTH = 12,
    parameter int MAT_BASE       = 0,
    parameter int S_BASE         = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  mode,
    output logic                                  busy,
    output logic                                  done,
    output logic [2:0]                            seed_addr,
    input  logic [DATA_W-1:0]                     seed_data,
    output logic                                  absorb_next,
    output logic [DATA_W-1:0]                     shake_data_in,
    output logic                                  in_valid,
    output logic                                  in_last,
    output logic [$clog2(DATA_W):0]               last_len,
    input  logic                                  in_ready,
    input  logic [DATA_W-1:0]                     shake_data_out,
    input  logic                                  out_valid,
    output logic                                  out_ready,
    output logic                                  we,
    output logic [NTT_ADDR_WIDTH-1:0]             addr,
    output logic [COEFF_WIDTH*COEFF_PER_WORD-1:0] din
);

    localparam int BUF_W     = DATA_W + 24;
    localparam int LEFT_W    = $clog2(BUF_W + 1);
    localparam int CNT_W     = $clog2(N + 1);
    localparam int SLOT_W    = (COEFF_PER_WORD > 1) ? $clog2(COEFF_PER_WORD) : 1;
    localparam int WPP       = N / COEFF_PER_WORD;
    localparam int PACK_W    = COEFF_WIDTH * COEFF_PER_WORD;
    localparam int SEED_A_M1 = 256 / DATA_W - 1;
    localparam int SEED_S_M1 = 512 / DATA_W - 1;
    localparam int NUM_A     = K * L;
    localparam int NUM_S     = K + L;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ABSORB,
        S_NONCE,
        S_SAMPLE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic                     mode_q, mode_d;
    logic [2:0]               seed_idx_q, seed_idx_d;
    logic [7:0]               r_q, r_d;
    logic [7:0]               s_q, s_d;
    logic [15:0]              poly_q, poly_d;
    logic [BUF_W-1:0]         bitbuf_q, bitbuf_d;
    logic [LEFT_W-1:0]        left_q, left_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [PACK_W-1:0]        pack_q, pack_d;

    logic [LEFT_W-1:0]        cw;
    logic [2:0]               seed_last;
    logic [15:0]              last_poly;
    logic [15:0]              nonce;
    logic                     cand_ok;
    logic [COEFF_WIDTH-1:0]   cand_coeff;
    logic [COEFF_WIDTH-1:0]   cand_a;
    logic [COEFF_WIDTH-1:0]   q_c;
    logic [3:0]               nib;
    logic [3:0]               nib_mod5;
    logic [SLOT_W-1:0]        slot;
    logic [PACK_W-1:0]        packed_word;

    assign last_len = ($clog2(DATA_W) + 1)'(16);

    // Mode-dependent constants: candidate width, seed length, polynomial
    // count and the nonce layout ({r, s} for ExpandA, r for ExpandS).
    always_comb begin
        cw        = mode_q ? LEFT_W'(4) : LEFT_W'(24);
        seed_last = mode_q ? 3'(SEED_S_M1) : 3'(SEED_A_M1);
        last_poly = mode_q ? 16'(NUM_S - 1) : 16'(NUM_A - 1);
        nonce     = mode_q ? poly_q : {r_q, s_q};
    end

    // Candidate test on the low bits of the buffer. Negative ExpandS values
    // are folded to Q + value so every stored coefficient stays in [0, Q).
    always_comb begin
        q_c        = COEFF_WIDTH'(Q);
        cand_a     = COEFF_WIDTH'(bitbuf_q[22:0]);
        nib        = bitbuf_q[3:0];
        nib_mod5   = nib % 4'd5;
        cand_ok    = 1'b0;
        cand_coeff = '0;
        if (!mode_q) begin
            cand_ok    = (cand_a < q_c);
            cand_coeff = cand_a;
        end else if (ETA == 4) begin
            cand_ok    = (nib < 4'd9);
            cand_coeff = (nib <= 4'd4) ? COEFF_WIDTH'(4'd4 - nib)
                                       : q_c - COEFF_WIDTH'(nib - 4'd4);
        end else begin
            cand_ok    = (nib < 4'd15);
            cand_coeff = (nib_mod5 <= 4'd2) ? COEFF_WIDTH'(4'd2 - nib_mod5)
                                            : q_c - COEFF_WIDTH'(nib_mod5 - 4'd2);
        end
        slot        = cnt_q[SLOT_W-1:0];
        packed_word = pack_q | (PACK_W'(cand_coeff) << (int'(slot) * COEFF_WIDTH));
    end

    // Next-state and output logic. In SAMPLE a cycle either loads a squeeze
    // word (buffer short of one candidate) or consumes one candidate, never
    // both, which keeps the buffer within DATA_W+24 bits.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        seed_idx_d    = seed_idx_q;
        r_d           = r_q;
        s_d           = s_q;
        poly_d        = poly_q;
        bitbuf_d      = bitbuf_q;
        left_d        = left_q;
        cnt_d         = cnt_q;
        pack_d        = pack_q;
        busy          = (state_q != S_IDLE);
        done          = 1'b0;
        seed_addr     = 3'd0;
        absorb_next   = 1'b0;
        shake_data_in = '0;
        in_valid      = 1'b0;
        in_last       = 1'b0;
        out_ready     = 1'b0;
        we            = 1'b0;
        addr          = '0;
        din           = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    poly_d  = '0;
                    r_d     = '0;
                    s_d     = '0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                absorb_next = 1'b1;
                bitbuf_d    = '0;
                left_d      = '0;
                cnt_d       = '0;
                pack_d      = '0;
                seed_idx_d  = '0;
                state_d     = S_ABSORB;
            end
            S_ABSORB: begin
                // The read address runs one word ahead of the word on the bus;
                // during a stall it repeats so seed_data stays put.
                in_valid      = 1'b1;
                shake_data_in = seed_data;
                seed_addr     = seed_idx_q;
                if (in_ready) begin
                    if (seed_idx_q == seed_last) begin
                        state_d = S_NONCE;
                    end else begin
                        seed_idx_d = seed_idx_q + 3'd1;
                        seed_addr  = seed_idx_q + 3'd1;
                    end
                end
            end
            S_NONCE: begin
                in_valid      = 1'b1;
                in_last       = 1'b1;
                shake_data_in = DATA_W'(nonce);
                if (in_ready) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (left_q < cw) begin
                    out_ready = 1'b1;
                    if (out_valid) begin
                        bitbuf_d = bitbuf_q | (BUF_W'(shake_data_out) << left_q);
                        left_d   = left_q + LEFT_W'(DATA_W);
                    end
                end else begin
                    bitbuf_d = bitbuf_q >> cw;
                    left_d   = left_q - cw;
                    if (cand_ok) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (slot == SLOT_W'(COEFF_PER_WORD - 1)) begin
                            we     = 1'b1;
                            din    = packed_word;
                            addr   = NTT_ADDR_WIDTH'((mode_q ? S_BASE : MAT_BASE)
                                     + int'(poly_q) * WPP
                                     + int'(cnt_q) / COEFF_PER_WORD);
                            pack_d = '0;
                        end else begin
                            pack_d = packed_word;
                        end
                        // Last coefficient: leftover bits are dropped here.
                        if (cnt_q == CNT_W'(N - 1)) begin
                            bitbuf_d = '0;
                            left_d   = '0;
                            state_d  = S_NEXT;
                        end
                    end
                end
            end
            S_NEXT: begin
                poly_d = poly_q + 16'd1;
                if (s_q == 8'(L - 1)) begin
                    s_d = '0;
                    r_d = r_q + 8'd1;
                end else begin
                    s_d = s_q + 8'd1;
                end
                state_d = (poly_q == last_poly) ? S_DONE : S_INIT;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            seed_idx_q <= '0;
            r_q        <= '0;
            s_q        <= '0;
            poly_q     <= '0;
            bitbuf_q   <= '0;
            left_q     <= '0;
            cnt_q      <= '0;
            pack_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            seed_idx_q <= seed_idx_d;
            r_q        <= r_d;
            s_q        <= s_d;
            poly_q     <= poly_d;
            bitbuf_q   <= bitbuf_d;
            left_q     <= left_d;
            cnt_q      <= cnt_d;
            pack_q     <= pack_d;
        end
    end

endmodule

// File: tb/tb_expand_sampler.sv
// ----------------------------------------------------------------------------
// tb_expand_sampler
//
// Two DUT instances: inst0 (K=2, L=2, ETA=2) and inst1 (K=1, L=1, ETA=4).
// A stub SHAKE core per instance emits a byte stream chosen by a pattern
// number and keyed by the absorbed nonce; a byte-level software model of
// rejection sampling builds the expected RAM image.
// ----------------------------------------------------------------------------
module tb_expand_sampler;

    localparam int Q = 8380417;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_en = 1'b0;

    logic        start_s       [2];
    logic        mode_s        [2];
    logic        busy_s        [2];
    logic        done_s        [2];
    logic [2:0]  seed_addr_s   [2];
    logic [63:0] seed_data_s   [2];
    logic        absorb_next_s [2];
    logic [63:0] shake_in_s    [2];
    logic        in_valid_s    [2];
    logic        in_last_s     [2];
    logic [6:0]  last_len_s    [2];
    logic        in_ready_s    [2];
    logic [63:0] sdo_s         [2];
    logic        out_valid_s   [2];
    logic        out_ready_s   [2];
    logic        we_s          [2];
    logic [11:0] addr_s        [2];
    logic [95:0] din_s         [2];

    // Stub and logging state, written only by the posedge process.
    int          wcnt       [2] = '{0, 0};
    int          aidx       [2] = '{0, 0};
    int          cur_nonce  [2] = '{0, 0};
    int          nlog_n     [2] = '{0, 0};
    int          wr_cnt     [2] = '{0, 0};
    int          done_cnt   [2] = '{0, 0};
    int          seed_err   [2] = '{0, 0};
    int          hold_err   [2] = '{0, 0};
    int          orb_err    [2] = '{0, 0};
    logic        first_pend [2] = '{1'b0, 1'b0};
    logic        hold_pv    [2] = '{1'b0, 1'b0};
    logic [63:0] hold_d     [2];
    logic        hold_l     [2];
    int          nlog       [2][256];
    int          faddr      [2][256];
    logic [95:0] fdin       [2][256];
    logic [95:0] ram        [2][4096];
    int          wgen       [2][4096];

    // Run control, written only by the initial block.
    int          pat_s      [2] = '{0, 0};
    int          run_mode   [2] = '{0, 0};
    int          gen = 0;
    logic [95:0] exp_img    [4096];
    int          errors = 0;
    int          checks = 0;
    int          base_nl, base_wr, base_done;

    always #5 clk = ~clk;

    expand_sampler #(.K(2), .L(2), .ETA(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .mode(mode_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .seed_addr(seed_addr_s[0]),
        .seed_data(seed_data_s[0]), .absorb_next(absorb_next_s[0]),
        .shake_data_in(shake_in_s[0]), .in_valid(in_valid_s[0]),
        .in_last(in_last_s[0]), .last_len(last_len_s[0]), .in_ready(in_ready_s[0]),
        .shake_data_out(sdo_s[0]), .out_valid(out_valid_s[0]),
        .out_ready(out_ready_s[0]), .we(we_s[0]), .addr(addr_s[0]), .din(din_s[0])
    );

    expand_sampler #(.K(1), .L(1), .ETA(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .mode(mode_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .seed_addr(seed_addr_s[1]),
        .seed_data(seed_data_s[1]), .absorb_next(absorb_next_s[1]),
        .shake_data_in(shake_in_s[1]), .in_valid(in_valid_s[1]),
        .in_last(in_last_s[1]), .last_len(last_len_s[1]), .in_ready(in_ready_s[1]),
        .shake_data_out(sdo_s[1]), .out_valid(out_valid_s[1]),
        .out_ready(out_ready_s[1]), .we(we_s[1]), .addr(addr_s[1]), .din(din_s[1])
    );

    function automatic logic [63:0] seed_val(input int inst, input int j);
        return {16'hA5C3, 8'(inst), 8'(j), 32'h1234_5678 + 32'(j)};
    endfunction

    // Squeeze byte k of the polynomial keyed by nonce, for each pattern.
    function automatic logic [7:0] gen_byte(input int pat, input int k, input int nonce);
        case (pat)
            0:       return (k < 3) ? 8'hFF : ((((k - 3) % 3) == 0) ? 8'h01 : 8'h00);
            1:       return (k == 0) ? 8'h3F : 8'h33;
            2:       return (k == 0) ? 8'h09 : 8'h00;
            default: return 8'((k * 73 + nonce * 29 + 17) ^ (k >> 3));
        endcase
    endfunction

    function automatic logic [63:0] gen_word(input int pat, input int w, input int nonce);
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < 8; b++) v[8*b +: 8] = gen_byte(pat, w * 8 + b, nonce);
        return v;
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) sdo_s[i] = gen_word(pat_s[i], wcnt[i], cur_nonce[i]);
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            in_ready_s[i]  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            out_valid_s[i] = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Stub SHAKE core, seed ROM, RAM model and protocol monitors.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            seed_data_s[i] <= seed_val(i, int'(seed_addr_s[i]));
            if (absorb_next_s[i]) begin
                wcnt[i] <= 0;
                aidx[i] <= 0;
            end
            if (in_valid_s[i] && in_ready_s[i]) begin
                if (!in_last_s[i]) begin
                    if (shake_in_s[i] !== seed_val(i, aidx[i])) seed_err[i] <= seed_err[i] + 1;
                    aidx[i] <= aidx[i] + 1;
                end else begin
                    if (aidx[i] != (run_mode[i] != 0 ? 8 : 4) || shake_in_s[i][63:16] !== 48'd0)
                        seed_err[i] <= seed_err[i] + 1;
                    cur_nonce[i] <= int'(shake_in_s[i][15:0]);
                    if (nlog_n[i] < 256) nlog[i][nlog_n[i]] <= int'(shake_in_s[i][15:0]);
                    nlog_n[i] <= nlog_n[i] + 1;
                    first_pend[i] <= 1'b1;
                end
            end
            if (out_valid_s[i] && out_ready_s[i]) wcnt[i] <= wcnt[i] + 1;
            if (we_s[i]) begin
                ram[i][addr_s[i]]  <= din_s[i];
                wgen[i][addr_s[i]] <= gen;
                wr_cnt[i]          <= wr_cnt[i] + 1;
                if (first_pend[i] && nlog_n[i] >= 1 && nlog_n[i] <= 256) begin
                    faddr[i][nlog_n[i] - 1] <= int'(addr_s[i]);
                    fdin[i][nlog_n[i] - 1]  <= din_s[i];
                    first_pend[i]           <= 1'b0;
                end
            end
            if (done_s[i]) done_cnt[i] <= done_cnt[i] + 1;
            if (out_ready_s[i] && !busy_s[i]) orb_err[i] <= orb_err[i] + 1;
            if (rst_n && hold_pv[i] &&
                (!in_valid_s[i] || shake_in_s[i] !== hold_d[i] || in_last_s[i] !== hold_l[i]))
                hold_err[i] <= hold_err[i] + 1;
            hold_pv[i] <= rst_n && in_valid_s[i] && !in_ready_s[i];
            hold_d[i]  <= shake_in_s[i];
            hold_l[i]  <= in_last_s[i];
        end
    end

    // Software rejection sampler producing the expected RAM image.
    task automatic build_expected(input int inst, input int md, input int pat, output int nwords);
        int kk, ll, eta, np, nonce, cnt, k, z, v;
        logic [7:0] by;
        kk  = (inst == 0) ? 2 : 1;
        ll  = (inst == 0) ? 2 : 1;
        eta = (inst == 0) ? 2 : 4;
        np  = (md == 0) ? kk * ll : kk + ll;
        nwords = np * 64;
        for (int p = 0; p < np; p++) begin
            nonce = (md != 0) ? p : (((p / ll) << 8) | (p % ll));
            cnt = 0;
            k = 0;
            while (cnt < 256) begin
                if (md == 0) begin
                    z = int'(gen_byte(pat, k, nonce)) | (int'(gen_byte(pat, k + 1, nonce)) << 8)
                        | (int'(gen_byte(pat, k + 2, nonce) & 8'h7F) << 16);
                    k += 3;
                    v = z;
                    if (z >= Q) z = -1;
                end else begin
                    by = gen_byte(pat, k / 2, nonce);
                    z = (k % 2 != 0) ? int'(by[7:4]) : int'(by[3:0]);
                    k++;
                    if (eta == 2) begin
                        v = 2 - (z % 5);
                        if (z >= 15) z = -1;
                    end else begin
                        v = 4 - z;
                        if (z >= 9) z = -1;
                    end
                    if (v < 0) v = Q + v;
                end
                if (z >= 0) begin
                    exp_img[p * 64 + cnt / 4][(cnt % 4) * 24 +: 24] = 24'(v);
                    cnt++;
                end
            end
        end
    endtask

    task automatic image_scan(input int inst, input int nwords, output int mm, output int fi);
        mm = 0;
        fi = -1;
        for (int a = 0; a < nwords; a++) begin
            if (wgen[inst][a] != gen || ram[inst][a] !== exp_img[a]) begin
                if (fi < 0) fi = a;
                mm++;
            end
        end
    endtask

    // Starts one run and waits for done under a cycle budget. With glitch
    // set, a second start with the other mode is pulsed while busy.
    task automatic run_job(input int inst, input int md, input int pat, input bit stall, input bit glitch);
        int cyc;
        pat_s[inst]    = pat;
        run_mode[inst] = md;
        stall_en       = stall;
        gen            = gen + 1;
        base_nl        = nlog_n[inst];
        base_wr        = wr_cnt[inst];
        base_done      = done_cnt[inst];
        @(negedge clk);
        mode_s[inst]  = (md != 0);
        start_s[inst] = 1'b1;
        @(negedge clk);
        start_s[inst] = 1'b0;
        mode_s[inst]  = 1'b0;
        cyc = 0;
        while (!done_s[inst] && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (glitch && cyc == 50) begin
                mode_s[inst]  = (md == 0);
                start_s[inst] = 1'b1;
                @(negedge clk);
                start_s[inst] = 1'b0;
                mode_s[inst]  = 1'b0;
                cyc++;
            end
        end
        checks++;
        if (!done_s[inst]) begin
            errors++;
            $display("[TB] FAIL run_timeout inst%0d mode%0d: no done after %0d cycles", inst, md, cyc);
        end
        stall_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        int w0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({busy_s[i], done_s[i], we_s[i], in_valid_s[i], in_last_s[i], out_ready_s[i],
                 absorb_next_s[i]} !== 7'd0 || addr_s[i] !== 12'd0 || din_s[i] !== 96'd0 ||
                seed_addr_s[i] !== 3'd0 || shake_in_s[i] !== 64'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs inst%0d: busy=%b done=%b we=%b in_valid=%b out_ready=%b absorb_next=%b addr=%h, all required 0",
                         i, busy_s[i], done_s[i], we_s[i], in_valid_s[i], out_ready_s[i], absorb_next_s[i], addr_s[i]);
            end
            checks++;
            if (last_len_s[i] !== 7'd16) begin
                errors++;
                $display("[TB] FAIL last_len inst%0d: got %0d required 16", i, last_len_s[i]);
            end
        end
        w0 = wr_cnt[0] + wr_cnt[1];
        repeat (10) @(negedge clk);
        checks++;
        if (wr_cnt[0] + wr_cnt[1] !== w0) begin
            errors++;
            $display("[TB] FAIL idle_no_we: got %0d writes required 0", wr_cnt[0] + wr_cnt[1] - w0);
        end
    endtask

    task automatic test_expand_a_accept();
        int nw, mm, fi;
        run_job(0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (fdin[0][base_nl] !== {4{24'd1}}) begin
            errors++;
            $display("[TB] FAIL a_first_din: got %h required %h", fdin[0][base_nl], {4{24'd1}});
        end
        checks++;
        if (faddr[0][base_nl] !== 0) begin
            errors++;
            $display("[TB] FAIL a_first_addr: got %0d required 0", faddr[0][base_nl]);
        end
        checks++;
        if (wr_cnt[0] - base_wr !== 256) begin
            errors++;
            $display("[TB] FAIL a_write_count: got %0d required 256", wr_cnt[0] - base_wr);
        end
        checks++;
        if (done_cnt[0] - base_done !== 1) begin
            errors++;
            $display("[TB] FAIL a_done_count: got %0d required 1", done_cnt[0] - base_done);
        end
        build_expected(0, 0, 0, nw);
        image_scan(0, nw, mm, fi);
        checks++;
        if (mm != 0) begin
            errors++;
            $display("[TB] FAIL a_image: %0d words differ, first %0d got %h required %h", mm, fi, ram[0][fi], exp_img[fi]);
        end
    endtask

    task automatic test_expand_a_nonce();
        int nw, mm, fi, want;
        run_job(0, 0, 3, 1'b0, 1'b0);
        for (int p = 0; p < 4; p++) begin
            want = ((p / 2) << 8) | (p % 2);
            checks++;
            if (nlog[0][base_nl + p] !== want) begin
                errors++;
                $display("[TB] FAIL a_nonce%0d: got %h required %h", p, nlog[0][base_nl + p], want);
            end
        end
        checks++;
        if (faddr[0][base_nl + 2] !== 128) begin
            errors++;
            $display("[TB] FAIL a_poly2_addr: got %0d required 128", faddr[0][base_nl + 2]);
        end
        build_expected(0, 0, 3, nw);
        image_scan(0, nw, mm, fi);
        checks++;
        if (mm != 0) begin
            errors++;
            $display("[TB] FAIL a_rand_image: %0d words differ, first %0d got %h required %h", mm, fi, ram[0][fi], exp_img[fi]);
        end
        checks++;
        if (seed_err[0] !== 0) begin
            errors++;
            $display("[TB] FAIL a_absorb_words: got %0d bad absorb words required 0", seed_err[0]);
        end
    endtask

    task automatic test_expand_s_eta2();
        int nw, mm, fi;
        run_job(0, 1, 1, 1'b0, 1'b0);
        checks++;
        if (fdin[0][base_nl] !== {4{24'd8380416}}) begin
            errors++;
            $display("[TB] FAIL s2_first_din: got %h required %h", fdin[0][base_nl], {4{24'd8380416}});
        end
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (nlog[0][base_nl + p] !== p) begin
                errors++;
                $display("[TB] FAIL s2_nonce%0d: got %0d required %0d", p, nlog[0][base_nl + p], p);
            end
        end
        run_job(0, 1, 3, 1'b0, 1'b0);
        build_expected(0, 1, 3, nw);
        image_scan(0, nw, mm, fi);
        checks++;
        if (mm != 0) begin
            errors++;
            $display("[TB] FAIL s2_rand_image: %0d words differ, first %0d got %h required %h", mm, fi, ram[0][fi], exp_img[fi]);
        end
        checks++;
        if (seed_err[0] !== 0) begin
            errors++;
            $display("[TB] FAIL s2_absorb_words: got %0d bad absorb words required 0", seed_err[0]);
        end
    endtask

    task automatic test_expand_s_eta4();
        int nw, mm, fi;
        run_job(1, 1, 2, 1'b0, 1'b0);
        checks++;
        if (fdin[1][base_nl] !== {4{24'd4}}) begin
            errors++;
            $display("[TB] FAIL s4_first_din: got %h required %h", fdin[1][base_nl], {4{24'd4}});
        end
        checks++;
        if (nlog[1][base_nl] !== 0 || nlog[1][base_nl + 1] !== 1) begin
            errors++;
            $display("[TB] FAIL s4_nonces: got %0d,%0d required 0,1", nlog[1][base_nl], nlog[1][base_nl + 1]);
        end
        checks++;
        if (wr_cnt[1] - base_wr !== 128) begin
            errors++;
            $display("[TB] FAIL s4_write_count: got %0d required 128", wr_cnt[1] - base_wr);
        end
        build_expected(1, 1, 2, nw);
        image_scan(1, nw, mm, fi);
        checks++;
        if (mm != 0) begin
            errors++;
            $display("[TB] FAIL s4_image: %0d words differ, first %0d got %h required %h", mm, fi, ram[1][fi], exp_img[fi]);
        end
    endtask

    task automatic test_backpressure();
        int nw, mm, fi;
        run_job(0, 0, 3, 1'b1, 1'b0);
        build_expected(0, 0, 3, nw);
        image_scan(0, nw, mm, fi);
        checks++;
        if (mm != 0) begin
            errors++;
            $display("[TB] FAIL bp_a_image: %0d words differ, first %0d got %h required %h", mm, fi, ram[0][fi], exp_img[fi]);
        end
        run_job(1, 0, 3, 1'b1, 1'b0);
        build_expected(1, 0, 3, nw);
        image_scan(1, nw, mm, fi);
        checks++;
        if (mm != 0) begin
            errors++;
            $display("[TB] FAIL bp_a1_image: %0d words differ, first %0d got %h required %h", mm, fi, ram[1][fi], exp_img[fi]);
        end
        run_job(0, 1, 3, 1'b1, 1'b0);
        build_expected(0, 1, 3, nw);
        image_scan(0, nw, mm, fi);
        checks++;
        if (mm != 0) begin
            errors++;
            $display("[TB] FAIL bp_s_image: %0d words differ, first %0d got %h required %h", mm, fi, ram[0][fi], exp_img[fi]);
        end
        checks++;
        if (hold_err[0] + hold_err[1] !== 0) begin
            errors++;
            $display("[TB] FAIL bp_hold_stable: got %0d unstable stalls required 0", hold_err[0] + hold_err[1]);
        end
        checks++;
        if (orb_err[0] + orb_err[1] !== 0 || seed_err[0] + seed_err[1] !== 0) begin
            errors++;
            $display("[TB] FAIL bp_protocol: out_ready_idle=%0d bad_absorb=%0d required 0,0",
                     orb_err[0] + orb_err[1], seed_err[0] + seed_err[1]);
        end
    endtask

    task automatic test_start_while_busy();
        int nw, mm, fi;
        run_job(0, 0, 3, 1'b0, 1'b1);
        checks++;
        if (done_cnt[0] - base_done !== 1 || nlog_n[0] - base_nl !== 4) begin
            errors++;
            $display("[TB] FAIL busy_start: done=%0d nonces=%0d required 1,4", done_cnt[0] - base_done, nlog_n[0] - base_nl);
        end
        build_expected(0, 0, 3, nw);
        image_scan(0, nw, mm, fi);
        checks++;
        if (mm != 0) begin
            errors++;
            $display("[TB] FAIL busy_start_image: %0d words differ, first %0d got %h required %h", mm, fi, ram[0][fi], exp_img[fi]);
        end
    endtask

    task automatic test_mid_reset();
        int nw, mm, fi, cyc, w;
        pat_s[0]    = 3;
        run_mode[0] = 0;
        gen         = gen + 1;
        base_nl     = nlog_n[0];
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        cyc = 0;
        while (nlog_n[0] < base_nl + 4 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (nlog_n[0] < base_nl + 4) begin
            errors++;
            $display("[TB] FAIL midreset_reach_poly3: got %0d nonces required 4", nlog_n[0] - base_nl);
        end
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (busy_s[0] !== 1'b0 || we_s[0] !== 1'b0 || out_ready_s[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: busy=%b we=%b out_ready=%b required 0", busy_s[0], we_s[0], out_ready_s[0]);
        end
        w = wr_cnt[0];
        repeat (30) @(negedge clk);
        checks++;
        if (wr_cnt[0] !== w) begin
            errors++;
            $display("[TB] FAIL midreset_no_we: got %0d writes required 0", wr_cnt[0] - w);
        end
        run_job(0, 0, 3, 1'b0, 1'b0);
        build_expected(0, 0, 3, nw);
        image_scan(0, nw, mm, fi);
        checks++;
        if (mm != 0) begin
            errors++;
            $display("[TB] FAIL midreset_image: %0d words differ, first %0d got %h required %h", mm, fi, ram[0][fi], exp_img[fi]);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            mode_s[i]  = 1'b0;
        end
        test_reset();
        test_expand_a_accept();
        test_expand_a_nonce();
        test_expand_s_eta2();
        test_expand_s_eta4();
        test_backpressure();
        test_start_while_busy();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
